i2c_target_regfile: RTL and testbench
=====================================

// Module: i2c_target_regfile
// PURPOSE
//  I2C target (slave) answering the HDMI-side 3-byte write frames [dev addr][reg addr][data] and register reads.
//  Oversamples SCL/SDA on the system clock and decodes START/STOP, address and ACK.
//  Drives an 8-bit register-file port. Used as the bench/loopback target for our I2C config master.
//  Also lets the FPGA expose config registers to an external host.
// PARAMETERS
//  DEV_ADDR     7'h39  7-bit target address; write frames carry byte 8'h72
//  SYNC_STAGES  2      synchroniser flops on scl_in/sda_in (>=2)
// PORTS
//  clk        in   1  system clock, >= 8x SCL frequency
//  reset_n    in   1  reset, synchronous, active-low
//  scl_in     in   1  raw SCL pin level (async)
//  sda_in     in   1  raw SDA pin level (async)
//  sda_oe     out  1  1 = pull SDA low (open-drain); 0 = release
//  reg_addr   out  8  register pointer
//  reg_wdata  out  8  write data, valid while reg_wr_en=1
//  reg_wr_en  out  1  one-clk write strobe
//  reg_rdata  in   8  read data for reg_addr, combinational from the register file
//  busy       out  1  1 from addressed-START until STOP
//  nack_rx    out  1  one-clk pulse when the master NACKs a read byte
// BEHAVIOUR
//  Reset values: sda_oe=0, reg_addr=0, reg_wdata=0, reg_wr_en=0, busy=0, nack_rx=0; state=IDLE.
//  Bus sampling:
//   - Both inputs pass SYNC_STAGES flops, then one history flop.
//   - Edges: scl_rise/scl_fall/sda_rise/sda_fall compare the synced value with the history flop.
//  Bus conditions:
//   - START = sda_fall while synced SCL=1; STOP = sda_rise while synced SCL=1.
//   - Both are checked before bit handling, in every state.
//   - START (incl. repeated) -> ADDR, bit count 0, sda_oe=0.
//   - STOP -> IDLE, sda_oe=0, busy=0.
//  Bit timing:
//   - Shift register captures SDA on scl_rise, MSB first; bit count 0..7.
//   - sda_oe changes only on scl_fall (or START/STOP/reset).
//  States:
//   - IDLE: ignore everything except START.
//   - ADDR: 8 bits. If byte[7:1]==DEV_ADDR: assert sda_oe on the next scl_fall (ACK), busy=1.
//     R/W=0 -> REG. R/W=1 -> RD.
//     Mismatch: no ACK, -> IDLE until the next START.
//   - ACK slot: sda_oe held through one SCL high; released on the following scl_fall.
//   - REG: 8 bits -> reg_addr <= byte; ACK; -> WR.
//   - WR: 8 bits -> reg_wdata <= byte and reg_wr_en=1 for exactly one clk at the 8th scl_rise+1 clk.
//     Then ACK, reg_addr <= reg_addr+1 (8'hFF wraps to 8'h00) at the ACK release; stay in WR.
//   - RD: at the scl_fall ending the address ACK, load the tx shift register from reg_rdata.
//     - Each scl_fall drives sda_oe = ~bit (MSB first).
//     - After 8 bits, release SDA and sample the master ACK on scl_rise.
//     - ACK=0: reg_addr+1 (wrap), reload from reg_rdata, continue.
//     - ACK=1: nack_rx pulse, sda_oe=0, -> IDLE (wait STOP/START).
//  Boundary conditions:
//   - Data bit 1 in RD never drives.
//   - START mid-byte aborts the byte, with no reg_wr_en.
//   - STOP during an ACK slot releases SDA immediately.
//   - A partial WR byte before STOP is discarded.
//  Reset mid-transfer: outputs return to reset values on the next clk; the bus is released.
// TESTING
//  1. Write 8'h72,8'h41,8'h10,STOP -> ACK x3; reg_wr_en once with reg_addr=8'h41, reg_wdata=8'h10; busy falls at STOP.
//  2. Write 8'h72,8'hFF,8'hAA,8'h55 -> writes (FF,AA) then (00,55); pointer wraps.
//  3. Address 8'h74 -> no ACK on any byte; no reg_wr_en; busy stays 0.
//  4. Write 8'h72,8'h20, rSTART, 8'h73; rdata(20)=8'hC3, rdata(21)=8'h5A; master ACK then NACK -> bytes C3,5A on SDA; nack_rx one pulse.
//  5. START mid-data-byte, or STOP in the ACK slot -> no write; sda_oe=0 within 1 clk of the condition; next frame decodes correctly.
//  6. reset_n=0 for 1 clk during RD bit 3 while driving low -> sda_oe=0, reg_addr=0, state IDLE; the next valid frame works.

Source files
------------

// File: rtl/i2c_target_regfile.sv
// I2C target with an 8-bit register-file port.
// Accepts [dev addr][reg addr][data...] write frames and register reads.
// SCL/SDA are oversampled on clk, so clk must run at >= 8x SCL.
//
// state  | meaning
// IDLE   | ignore the bus until a START
// ADDR   | receiving the device address byte
// REG    | receiving the register pointer byte
// WR     | receiving data bytes, pointer auto-increments
// RD     | transmitting register bytes, pointer auto-increments on master ACK
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR    = 7'h39,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       nack_rx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_REG,
    S_WR,
    S_RD
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   sda_rise;
  logic                   sda_fall;
  logic                   start_cond;
  logic                   stop_cond;
  logic [6:0]             shift;
  logic [7:0]             rx_byte;
  logic [6:0]             tx;
  logic [3:0]             bit_cnt;
  logic                   in_ack;
  logic                   rw;

  // Synchronise the raw pins and keep one history sample for edge detection.
  // Idle bus level is high, so the chain resets to ones.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_hist <= scl_s;
      sda_hist <= sda_s;
    end
  end

  assign scl_s      = scl_sync[SYNC_STAGES-1];
  assign sda_s      = sda_sync[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_hist;
  assign scl_fall   = ~scl_s & scl_hist;
  assign sda_rise   = sda_s & ~sda_hist;
  assign sda_fall   = ~sda_s & sda_hist;
  assign start_cond = sda_fall & scl_s;
  assign stop_cond  = sda_rise & scl_s;
  assign rx_byte    = {shift, sda_s};

  // Protocol FSM: bus conditions first, then per-state bit handling.
  // bit_cnt counts SCL rises 0..8; in_ack marks the ninth (ACK) clock.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      sda_oe    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_wr_en <= 1'b0;
      busy      <= 1'b0;
      nack_rx   <= 1'b0;
      shift     <= 7'h00;
      tx        <= 7'h00;
      bit_cnt   <= 4'd0;
      in_ack    <= 1'b0;
      rw        <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      nack_rx   <= 1'b0;
      if (stop_cond) begin
        state   <= S_IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        in_ack  <= 1'b0;
        bit_cnt <= 4'd0;
      end else if (start_cond) begin
        state   <= S_ADDR;
        sda_oe  <= 1'b0;
        in_ack  <= 1'b0;
        bit_cnt <= 4'd0;
      end else begin
        case (state)
          S_IDLE: begin
          end
          S_ADDR, S_REG, S_WR: begin
            if (scl_rise && !in_ack && bit_cnt != 4'd8) begin
              shift   <= rx_byte[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                case (state)
                  S_ADDR: begin
                    if (rx_byte[7:1] == DEV_ADDR) begin
                      busy <= 1'b1;
                      rw   <= rx_byte[0];
                    end else begin
                      state <= S_IDLE;
                    end
                  end
                  S_REG: reg_addr <= rx_byte;
                  S_WR: begin
                    reg_wdata <= rx_byte;
                    reg_wr_en <= 1'b1;
                  end
                  default: begin
                  end
                endcase
              end
            end else if (scl_fall && !in_ack && bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
              in_ack <= 1'b1;
            end else if (scl_fall && in_ack) begin
              sda_oe  <= 1'b0;
              in_ack  <= 1'b0;
              bit_cnt <= 4'd0;
              case (state)
                S_ADDR: begin
                  if (rw) begin
                    // First read byte goes out on the same fall that ends the ACK.
                    state  <= S_RD;
                    tx     <= reg_rdata[6:0];
                    sda_oe <= ~reg_rdata[7];
                  end else begin
                    state <= S_REG;
                  end
                end
                S_REG:   state <= S_WR;
                S_WR:    reg_addr <= reg_addr + 8'd1;
                default: begin
                end
              endcase
            end
          end
          S_RD: begin
            if (scl_rise && !in_ack && bit_cnt != 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && !in_ack) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                in_ack <= 1'b1;
              end else if (bit_cnt != 4'd0) begin
                sda_oe <= ~tx[6];
                tx     <= {tx[5:0], 1'b0};
              end
            end else if (scl_rise && in_ack) begin
              if (!sda_s) begin
                reg_addr <= reg_addr + 8'd1;
              end else begin
                nack_rx <= 1'b1;
                sda_oe  <= 1'b0;
                in_ack  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= S_IDLE;
              end
            end else if (scl_fall && in_ack) begin
              // Pointer already advanced on the ACK, so reg_rdata is the next byte.
              in_ack  <= 1'b0;
              bit_cnt <= 4'd0;
              tx      <= reg_rdata[6:0];
              sda_oe  <= ~reg_rdata[7];
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, open-drain SDA model,
// a register-file model, and scoreboard monitors for the register port,
// NACK pulses and target-driven bus slots.
module tb_i2c_target_regfile;

  localparam int Q = 5;

  typedef struct {
    logic [7:0] val;
    int         nbits;
  } slot_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_in = 1'b1;
  logic       sda_drv = 1'b1;
  logic       ovr = 1'b0;
  logic       tgt_slot = 1'b0;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       nack_rx;
  logic [7:0] mem [256];
  logic [15:0] wr_e;

  slot_t       exp_slot[$];
  logic [15:0] exp_wr[$];
  int          exp_nack[$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Wired-AND SDA; ovr lets the master force the line to inject a STOP
  // while the target is still holding its ACK.
  assign sda_in = ovr ? sda_drv : (sda_drv & ~sda_oe);

  always_comb reg_rdata = mem[reg_addr];

  i2c_target_regfile dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .nack_rx   (nack_rx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected at %0t", name, act, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (!scl_in) begin
      sda_drv = 1'b1;
      tick(Q);
      scl_in = 1'b1;
      tick(Q);
    end
    sda_drv = 1'b0;
    tick(Q);
    scl_in = 1'b0;
    tick(Q);
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0;
    tick(Q);
    scl_in = 1'b1;
    tick(Q);
    sda_drv = 1'b1;
    tick(Q);
  endtask

  task automatic clock_bit(input logic b, input logic tgt);
    sda_drv = b;
    tick(Q);
    tgt_slot = tgt;
    scl_in = 1'b1;
    tick(2 * Q);
    scl_in = 1'b0;
    tgt_slot = 1'b0;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack);
    for (int i = 7; i >= 0; i--) clock_bit(b[i], 1'b0);
    exp_slot.push_back('{val: 8'(exp_ack), nbits: 1});
    clock_bit(1'b1, 1'b1);
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic mack);
    exp_slot.push_back('{val: exp, nbits: 8});
    for (int i = 0; i < 8; i++) clock_bit(1'b1, 1'b1);
    clock_bit(mack, 1'b0);
  endtask

  // Bus monitor: collects line levels of target-driven slots and checks them.
  initial begin : mon_bus
    logic [7:0] acc;
    int         cnt;
    slot_t      s;
    acc = 8'h00;
    cnt = 0;
    forever begin
      @(posedge scl_in);
      @(negedge clk);
      if (tgt_slot) begin
        acc = {acc[6:0], sda_in};
        cnt++;
        if (exp_slot.size() == 0) begin
          unexpected("bus_slot_unexpected", 32'(acc));
          acc = 8'h00;
          cnt = 0;
        end else if (cnt == exp_slot[0].nbits) begin
          s = exp_slot.pop_front();
          chk("bus_slot", 32'(acc), 32'(s.val));
          acc = 8'h00;
          cnt = 0;
        end
      end
    end
  end

  // Register-port monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (reg_wr_en === 1'b1) begin
      if (exp_wr.size() == 0) begin
        unexpected("wr_unexpected", 32'({reg_addr, reg_wdata}));
      end else begin
        wr_e = exp_wr.pop_front();
        chk("wr_port", 32'({reg_addr, reg_wdata}), 32'(wr_e));
      end
    end
  end

  // NACK monitor: each nack_rx clock must be matched by one expected pulse.
  always @(negedge clk) begin
    if (nack_rx === 1'b1) begin
      if (exp_nack.size() == 0) unexpected("nack_unexpected", 32'(nack_rx));
      else chk("nack_rx", 32'(nack_rx), 32'(exp_nack.pop_front()));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h20] = 8'hC3;
    mem[8'h21] = 8'h5A;

    reset_n = 1'b0;
    tick(4);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    chk("rst_reg_wr_en", 32'(reg_wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_nack_rx", 32'(nack_rx), 32'd0);
    reset_n = 1'b1;
    tick(4);

    // Single write 41 <- 10
    exp_wr.push_back({8'h41, 8'h10});
    bus_start();
    send_byte(8'h72, 1'b0);
    chk("t1_busy_set", 32'(busy), 32'd1);
    send_byte(8'h41, 1'b0);
    send_byte(8'h10, 1'b0);
    bus_stop();
    tick(3);
    chk("t1_busy_clr", 32'(busy), 32'd0);
    chk("t1_reg_addr", 32'(reg_addr), 32'h42);

    // Pointer wrap FF -> 00
    exp_wr.push_back({8'hFF, 8'hAA});
    exp_wr.push_back({8'h00, 8'h55});
    bus_start();
    send_byte(8'h72, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h55, 1'b0);
    bus_stop();
    tick(3);
    chk("t2_reg_addr", 32'(reg_addr), 32'h01);

    // Wrong device address: silent, no busy
    bus_start();
    send_byte(8'h74, 1'b1);
    chk("t3_busy_addr", 32'(busy), 32'd0);
    send_byte(8'h41, 1'b1);
    send_byte(8'h10, 1'b1);
    bus_stop();
    tick(3);
    chk("t3_busy_end", 32'(busy), 32'd0);

    // Pointer write, repeated START, read C3 (ACK) then 5A (NACK)
    bus_start();
    send_byte(8'h72, 1'b0);
    send_byte(8'h20, 1'b0);
    bus_start();
    send_byte(8'h73, 1'b0);
    read_byte(8'hC3, 1'b0);
    exp_nack.push_back(1);
    read_byte(8'h5A, 1'b1);
    chk("t4_busy_after_nack", 32'(busy), 32'd1);
    chk("t4_sda_released", 32'(sda_oe), 32'd0);
    bus_stop();
    tick(3);
    chk("t4_busy_clr", 32'(busy), 32'd0);
    chk("t4_reg_addr", 32'(reg_addr), 32'h21);

    // STOP inside the ACK slot of the pointer byte
    bus_start();
    send_byte(8'h72, 1'b0);
    for (int i = 7; i >= 0; i--) clock_bit(1'(8'h30 >> i), 1'b0);
    ovr = 1'b1;
    sda_drv = 1'b0;
    tick(Q);
    scl_in = 1'b1;
    tick(Q);
    chk("t5_ack_held", 32'(sda_oe), 32'd1);
    sda_drv = 1'b1;
    tick(3);
    chk("t5_stop_release", 32'(sda_oe), 32'd0);
    chk("t5_stop_busy", 32'(busy), 32'd0);
    ovr = 1'b0;
    tick(Q);

    // START mid data byte aborts it; following frame writes 60 <- 77
    exp_wr.push_back({8'h60, 8'h77});
    bus_start();
    send_byte(8'h72, 1'b0);
    send_byte(8'h50, 1'b0);
    clock_bit(1'b1, 1'b0);
    clock_bit(1'b0, 1'b0);
    clock_bit(1'b1, 1'b0);
    clock_bit(1'b0, 1'b0);
    bus_start();
    chk("t5_start_sda_oe", 32'(sda_oe), 32'd0);
    send_byte(8'h72, 1'b0);
    send_byte(8'h60, 1'b0);
    send_byte(8'h77, 1'b0);
    bus_stop();
    tick(3);
    chk("t5_reg_addr", 32'(reg_addr), 32'h61);

    // Reset while the target drives a low read bit
    bus_start();
    send_byte(8'h72, 1'b0);
    send_byte(8'h20, 1'b0);
    bus_start();
    send_byte(8'h73, 1'b0);
    exp_slot.push_back('{val: 8'h06, nbits: 3});
    for (int i = 0; i < 3; i++) clock_bit(1'b1, 1'b1);
    chk("t6_driving_low", 32'(sda_oe), 32'd1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk("t6_rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("t6_rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    tick(4);
    bus_stop();
    exp_wr.push_back({8'h05, 8'h99});
    bus_start();
    send_byte(8'h72, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h99, 1'b0);
    bus_stop();
    tick(3);
    chk("t6_reg_addr", 32'(reg_addr), 32'h06);
    chk("t6_busy_clr", 32'(busy), 32'd0);

    tick(10);
    chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    chk("slot_queue_drained", 32'(exp_slot.size()), 32'd0);
    chk("nack_queue_drained", 32'(exp_nack.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
